// File: rtl/store_buffer.sv
// In-order store queue: captures resolved stores from the CDB, holds them until
// the ROB commits their tag, drains committed stores to memory in program order.
module store_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cdb_in_valid,
  input  logic [TAG_W-1:0] cdb_in_index,
  input  logic [31:0]      cdb_in_addr,
  input  logic [31:0]      cdb_in_result,
  input  logic [1:0]       cdb_in_size,
  output logic             full,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             br,
  input  logic             check_load_enable,
  input  logic [31:0]      check_load_addr,
  output logic             can_load_enable,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [3:0]       mem_sel_o,
  input  logic             mem_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d, cmt_q, cmt_d, cmt_c, hit;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [CNT_W-1:0] count_q, count_d, plen;
  logic [0:0]       state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [3:0]       mem_sel_q, mem_sel_d;
  logic             enq, pop, run;
  logic [3:0]       head_sel;
  logic [31:0]      head_data;
  logic             unused_check_bits;

  assign full = (count_q == CNT_W'(DEPTH));
  assign enq  = cdb_in_valid && (cdb_in_index != '0) && !full && !br;
  // Misaligned entries carry no strobe and retire without waiting for memory.
  assign pop  = (state_q == WRITE) && (mem_ready || !mem_we_q);

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_sel_o  = mem_sel_q;

  assign unused_check_bits = ^check_load_addr[1:0];

  always_comb begin
    head_sel  = '0;
    head_data = data_q[head_q];
    case (size_q[head_q])
      2'b00: begin
        head_sel  = 4'b0001 << addr_q[head_q][1:0];
        head_data = {4{data_q[head_q][7:0]}};
      end
      2'b01: begin
        head_data = {2{data_q[head_q][15:0]}};
        if (!addr_q[head_q][0]) head_sel = addr_q[head_q][1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   head_sel = 4'b1111;
      default: head_sel = '0;
    endcase
  end

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      hit[i] = valid_q[i] && (addr_q[i][31:2] == check_load_addr[31:2]);
  end

  assign can_load_enable = !(check_load_enable && (|hit));

  always_comb begin
    valid_d    = valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_sel_d  = mem_sel_q;
    idx        = '0;
    plen       = '0;
    run        = 1'b1;

    cmt_c = cmt_q;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (commit_valid && valid_q[i] && (tag_q[i] == commit_tag)) cmt_c[i] = 1'b1;
    cmt_d = cmt_c;

    case (state_q)
      IDLE: begin
        if ((count_q != '0) && cmt_q[head_q]) begin
          mem_addr_d = {addr_q[head_q][31:2], 2'b00};
          mem_data_d = head_data;
          mem_sel_d  = head_sel;
          mem_we_d   = (head_sel != '0);
          state_d    = WRITE;
        end
      end
      default: begin
        if (pop) begin
          mem_we_d         = 1'b0;
          state_d          = IDLE;
          valid_d[head_q]  = 1'b0;
          cmt_d[head_q]    = 1'b0;
          head_d           = head_q + 1'b1;
        end
      end
    endcase

    // Flush keeps only the committed prefix counted from the pre-pop head.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (run && (CNT_W'(k) < count_q) && cmt_c[idx]) plen = plen + 1'b1;
      else run = 1'b0;
    end

    if (br) begin
      valid_d = valid_d & cmt_c;
      tail_d  = head_q + plen[PTR_W-1:0];
      count_d = plen - CNT_W'(pop);
    end else begin
      if (enq) begin
        valid_d[tail_q] = 1'b1;
        cmt_d[tail_q]   = commit_valid && (commit_tag == cdb_in_index);
        tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      cmt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_sel_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      cmt_q      <= cmt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_sel_q  <= mem_sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && enq) begin
      tag_q[tail_q]  <= cdb_in_index;
      addr_q[tail_q] <= cdb_in_addr;
      data_q[tail_q] <= cdb_in_result;
      size_q[tail_q] <= cdb_in_size;
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order store queue on the memory side of the out-of-order core.
- Captures store address/data/size broadcast on the CDB by the load/store unit and holds each store until the reorder buffer commits its tag.
- Drains committed stores to data memory in program order.
- Answers the load unit's load-address conflict check, so a load never bypasses an older store to the same word.

Parameters:
DEPTH, 8, number of entries; power of two, minimum 2
TAG_W, 8, width of a ROB tag; tag 0 means "no tag"

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset (cleared state while rst==0 at a clk edge)
cdb_in_valid  input  1  CDB broadcast is a resolved store
cdb_in_index  input  TAG_W  ROB tag of the store
cdb_in_addr  input  32  store byte address
cdb_in_result  input  32  store data, right-justified
cdb_in_size  input  2  00=SB, 01=SH, 10=SW; 11 is illegal
full  output  1  1 when occupancy==DEPTH
commit_valid  input  1  ROB retires a store this cycle
commit_tag  input  TAG_W  tag being retired
br  input  1  branch mispredict flush
check_load_enable  input  1  load unit requests a conflict check
check_load_addr  input  32  load byte address
can_load_enable  output  1  combinational; 1 = no older buffered store to the same word
mem_we_o  output  1  memory write strobe
mem_addr_o  output  32  word-aligned write address ({addr[31:2],2'b00})
mem_data_o  output  32  write data shifted to its byte lane
mem_sel_o  output  4  byte enables
mem_ready  input  1  memory accepts the write this cycle

Behaviour:
- Storage: circular queue with head, tail and count. Each entry holds tag, addr, data, size and a committed bit.
- Reset values: all entries invalid; head=tail=count=0; full=0; mem_we_o=0; mem_addr_o=0; mem_data_o=0; mem_sel_o=0; FSM in IDLE.
- Enqueue:
  - Condition: cdb_in_valid && cdb_in_index!=0 && !full && !br.
  - Writes the entry at tail; tail advances modulo DEPTH; count increments.
  - Enqueue while full is dropped silently; upstream must stall on full.
- Commit:
  - commit_valid marks the entry whose tag == commit_tag as committed.
  - If commit_tag equals cdb_in_index of a same-cycle enqueue, the new entry is written already committed.
  - A commit with no matching tag is ignored.
- Byte lanes:
  - SB: sel = 0001 << addr[1:0]; data = result[7:0] replicated to all four byte lanes.
  - SH: addr[1]=0 gives sel 0011; addr[1]=1 gives sel 1100; data = {2{result[15:0]}}. addr[0]=1 is misaligned: sel=0000, the entry drains with no write strobe and is popped silently.
  - SW: sel=1111; addr[1:0] ignored.
  - Size 11: treated as misaligned (same as misaligned SH).
- Drain FSM:
  - IDLE: if count>0 and the head entry is committed, load mem_addr_o/mem_data_o/mem_sel_o from head, set mem_we_o=1 (sel!=0) and go to WRITE. First strobe is 1 cycle after the commit edge.
  - WRITE: hold all memory outputs stable until mem_ready==1. On that edge: pop head, count decrements, mem_we_o=0, return to IDLE.
  - Minimum 2 cycles per store. A misaligned entry pops at the WRITE edge regardless of mem_ready.
- Simultaneous enqueue and pop in one cycle: count unchanged; both pointers advance.
- Conflict check:
  - can_load_enable = 0 iff check_load_enable and any valid entry has addr[31:2]==check_load_addr[31:2]. Entries include committed ones and the one currently in WRITE.
  - can_load_enable = 1 when check_load_enable==0.
  - No forwarding.
- Flush (br=1):
  - All uncommitted entries are discarded; tail = head + committed-prefix length.
  - Committed entries are architectural and remain; they form a contiguous prefix from head because commits arrive in order.
  - An in-flight WRITE completes normally.
  - Enqueue in a br cycle is ignored; a commit in a br cycle is still applied before the discard.
- Reset mid-WRITE: the write is abandoned; mem_we_o drops at that edge.
- Pointer wrap: head and tail wrap DEPTH-1 to 0; full and empty are derived from count, never from pointer equality.

Test Plan:
- Reset, then enqueue tag 5 SW addr 0x100 data 0xDEADBEEF, commit 5, mem_ready=1 -> mem_we_o=1 one cycle after commit with addr 0x100, sel 1111, data 0xDEADBEEF; count returns to 0 two cycles after commit.
- Enqueue SB addr 0x203 data 0x5A, commit -> sel 1000, mem_data_o=0x5A5A5A5A, mem_addr_o=0x200. Enqueue SH addr 0x206 data 0x1234, commit -> sel 1100, data 0x12341234.
- Enqueue tag 7 SW addr 0x40 uncommitted; check_load_addr 0x42 -> can_load_enable=0; check 0x44 -> 1; after 7 commits and drains, check 0x42 -> 1.
- Fill 8 entries (tags 1..8) -> full=1, ninth enqueue dropped; commit 1..3, pulse br -> count=3 with tags 1..3 drained in order; tail wraps correctly on the next 8 enqueues.
- Hold mem_ready=0 for 4 cycles in WRITE -> outputs stable and head not popped; same-cycle enqueue plus commit of a new tag -> entry stored committed and drains next.
